// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every handshake/bus signal of mem_port_arbiter:
//   if_*   : instruction-fetch requester (read-only), level req / pulse ack
//   mem_*  : MEM-stage requester (load/store), level req / pulse ack
//   bus_*  : single-ported backing memory, req held until one-cycle ack
//   busy_o : arbiter not idle
//   err_o  : sticky timeout flag
// Modports:
//   slave  : the arbiter's view (drives acks, read data and the bus request)
//   master : the environment's view (drives requests and the bus response)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_ack_o;
    logic [DATA_W-1:0] mem_rdata_o;

    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;

    logic              busy_o;
    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_ack_o, if_rdata_o,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        output mem_ack_o, mem_rdata_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i,
        output busy_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_ack_o, if_rdata_o,
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        input  mem_ack_o, mem_rdata_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i,
        input  busy_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported backing memory between the instruction-fetch
// requester (read-only) and the MEM-stage requester (load/store). Each access
// runs IDLE -> BUS -> DONE -> IDLE. MEM wins ties unless it has already taken
// MAX_MEM_BURST consecutive grants while IF was waiting. A bus access that sees
// no ack within TIMEOUT cycles is aborted, completes with zero data and sets the
// sticky err_o.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   port_if : mem_port_arbiter_if.slave (requester, backing bus, status)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int TIMEOUT       = 255,
    parameter int MAX_MEM_BURST = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   port_if
);

    localparam int TMR_W  = $clog2(TIMEOUT);
    localparam int STRK_W = $clog2(MAX_MEM_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic                owner_mem_q, owner_mem_d;
    logic                bus_req_q,   bus_req_d;
    logic                bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [TMR_W-1:0]    timer_q,     timer_d;
    logic [STRK_W-1:0]   streak_q,    streak_d;
    logic                if_ack_q,    if_ack_d;
    logic                mem_ack_q,   mem_ack_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                err_q,       err_d;
    logic                busy_q,      busy_d;

    logic                grant_mem_s;
    logic                grant_if_s;
    logic                streak_full_s;
    logic                finish_s;
    logic [DATA_W-1:0]   capture_s;

    // Grant decision: only meaningful while idle; MEM yields once its streak is full.
    always_comb begin
        streak_full_s = (streak_q == STRK_W'(MAX_MEM_BURST));
        if (state_q == ST_IDLE) begin
            grant_mem_s = port_if.mem_req_i & (~port_if.if_req_i | ~streak_full_s);
            grant_if_s  = port_if.if_req_i & ~grant_mem_s;
        end else begin
            grant_mem_s = 1'b0;
            grant_if_s  = 1'b0;
        end
    end

    // Consecutive-MEM-grant counter, reset whenever IF is not waiting or gets served.
    always_comb begin
        streak_d = streak_q;
        if (!port_if.if_req_i) begin
            streak_d = '0;
        end else if (grant_if_s) begin
            streak_d = '0;
        end else if (grant_mem_s && !streak_full_s) begin
            streak_d = streak_q + STRK_W'(1);
        end else begin
            streak_d = streak_q;
        end
    end

    // FSM next state and all registered-output next values.
    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        timer_d     = timer_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        err_d       = err_q;
        finish_s    = 1'b0;
        capture_s   = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_mem_s) begin
                    state_d     = ST_BUS;
                    owner_mem_d = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = port_if.mem_we_i;
                    bus_addr_d  = port_if.mem_addr_i;
                    bus_wdata_d = port_if.mem_wdata_i;
                    timer_d     = '0;
                end else if (grant_if_s) begin
                    state_d     = ST_BUS;
                    owner_mem_d = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = port_if.if_addr_i;
                    bus_wdata_d = '0;
                    timer_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // An ack in the timeout cycle wins, so it is tested first.
                if (port_if.bus_ack_i) begin
                    finish_s  = 1'b1;
                    capture_s = bus_we_q ? '0 : port_if.bus_rdata_i;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    finish_s  = 1'b1;
                    capture_s = '0;
                    err_d     = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (finish_s) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (owner_mem_q) begin
                        mem_ack_d   = 1'b1;
                        mem_rdata_d = capture_s;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = capture_s;
                    end
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_DONE: begin
                // Requests are deliberately not sampled here so a requester still
                // holding req during its ack cycle is not served twice.
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            owner_mem_q <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            timer_q     <= '0;
            streak_q    <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            timer_q     <= timer_d;
            streak_q    <= streak_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign port_if.if_ack_o    = if_ack_q;
    assign port_if.if_rdata_o  = if_rdata_q;
    assign port_if.mem_ack_o   = mem_ack_q;
    assign port_if.mem_rdata_o = mem_rdata_q;
    assign port_if.bus_req_o   = bus_req_q;
    assign port_if.bus_we_o    = bus_we_q;
    assign port_if.bus_addr_o  = bus_addr_q;
    assign port_if.bus_wdata_o = bus_wdata_q;
    assign port_if.busy_o      = busy_q;
    assign port_if.err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Table of single-requester transactions plus hand-written sequences for tie
// breaking, the MEM burst limit, timeout, asynchronous reset and held requests.
// A background responder plays the backing memory with a programmable latency.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 8;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .MAX_MEM_BURST(4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .port_if (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // responder controls
    logic        resp_en    = 1'b0;
    int          resp_lat   = 0;
    logic [31:0] resp_rdata = 32'h0;

    // monitors
    logic [31:0] grant_log[$];
    int          if_acks  = 0;
    int          mem_acks = 0;
    logic        prev_req = 1'b0;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        int          lat;
        logic [31:0] rdata;
        logic        exp_mem;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // backing memory model: ack resp_lat negedges after bus_req_o is first seen
    initial begin
        int cnt;
        cnt = 0;
        bif.bus_ack_i   = 1'b0;
        bif.bus_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            bif.bus_ack_i = 1'b0;
            if (resp_en && bif.bus_req_o) begin
                if (cnt == resp_lat) begin
                    bif.bus_ack_i   = 1'b1;
                    bif.bus_rdata_i = resp_rdata;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // grant and ack monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bif.bus_req_o && !prev_req) grant_log.push_back(bif.bus_addr_o);
            prev_req = bif.bus_req_o;
            if (bif.if_ack_o)  if_acks++;
            if (bif.mem_ack_o) mem_acks++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_bus_req(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bif.bus_req_o) break;
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bif.if_ack_o || bif.mem_ack_o) break;
        end
    endtask

    task automatic run_vec(input vec_t v, input logic exp_err, input string tag);
        int n;
        @(negedge clk);
        resp_lat        = v.lat;
        resp_rdata      = v.rdata;
        resp_en         = 1'b1;
        bif.if_req_i    = v.if_req;
        bif.if_addr_i   = v.if_addr;
        bif.mem_req_i   = v.mem_req;
        bif.mem_we_i    = v.mem_we;
        bif.mem_addr_i  = v.mem_addr;
        bif.mem_wdata_i = v.mem_wdata;
        wait_bus_req(n);
        chk({tag, "_req_lat"}, 64'(n), 64'd1);
        chk({tag, "_addr"},  64'(bif.bus_addr_o),  64'(v.exp_addr));
        chk({tag, "_we"},    64'(bif.bus_we_o),    64'(v.exp_we));
        chk({tag, "_wdata"}, 64'(bif.bus_wdata_o), 64'(v.exp_wdata));
        chk({tag, "_busy"},  64'(bif.busy_o),      64'd1);
        wait_ack(n);
        chk({tag, "_ack_lat"}, 64'(n), 64'(v.lat + 1));
        chk({tag, "_own_ack"}, 64'(v.exp_mem ? bif.mem_ack_o : bif.if_ack_o), 64'd1);
        chk({tag, "_oth_ack"}, 64'(v.exp_mem ? bif.if_ack_o : bif.mem_ack_o), 64'd0);
        chk({tag, "_rdata"},
            64'(v.exp_mem ? bif.mem_rdata_o : bif.if_rdata_o), 64'(v.exp_rdata));
        chk({tag, "_err"}, 64'(bif.err_o), 64'(exp_err));
        bif.if_req_i  = 1'b0;
        bif.mem_req_i = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, 64'(bif.if_ack_o | bif.mem_ack_o), 64'd0);
        chk({tag, "_idle"}, 64'(bif.busy_o), 64'd0);
    endtask

    initial begin
        int n, hi, cyc, mdone, base, ibase, mbase;
        logic idone;
        logic [31:0] exp_g[7];
        logic [63:0] got;

        exp_g[0] = 32'h100; exp_g[1] = 32'h101; exp_g[2] = 32'h102; exp_g[3] = 32'h103;
        exp_g[4] = 32'h020; exp_g[5] = 32'h104; exp_g[6] = 32'h105;

        //          if_req if_addr         mem_req we    mem_addr      mem_wdata     lat rdata          mem   exp_addr      we    wdata         exp_rdata
        vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,        32'h0,        3, 32'hDEAD_BEEF, 1'b0, 32'h0000_0010, 1'b0, 32'h0,        32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0044, 32'h1111_1111, 0, 32'hCAFE_F00D, 1'b1, 32'h0000_0044, 1'b0, 32'h1111_1111, 32'hCAFE_F00D};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0048, 32'h1234_5678, 2, 32'h5555_5555, 1'b1, 32'h0000_0048, 1'b1, 32'h1234_5678, 32'h0};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,        32'h0,        1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0,        32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 32'h0000_0030, 1'b0, 1'b0, 32'h0,        32'h0,        7, 32'h0BAD_F00D, 1'b0, 32'h0000_0030, 1'b0, 32'h0,        32'h0BAD_F00D};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0,        5, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0000_0001};

        rst_n = 1'b0;
        bif.if_req_i = 1'b0; bif.if_addr_i = 32'h0;
        bif.mem_req_i = 1'b0; bif.mem_we_i = 1'b0; bif.mem_addr_i = 32'h0; bif.mem_wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", 64'(bif.bus_req_o), 64'd0);
        chk("rst_busy",    64'(bif.busy_o),    64'd0);
        chk("rst_err",     64'(bif.err_o),     64'd0);
        chk("rst_acks",    64'({bif.if_ack_o, bif.mem_ack_o}), 64'd0);
        chk("rst_rdata",   64'({bif.if_rdata_o, bif.mem_rdata_o}), 64'd0);
        chk("rst_addr",    64'(bif.bus_addr_o), 64'd0);
        rst_n = 1'b1;

        // table of single transactions (vector 4 acks exactly in the timeout cycle)
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], 1'b0, $sformatf("v%0d", i));
        end
        chk("if_rdata_hold", 64'(bif.if_rdata_o), 64'h0BAD_F00D);

        // tie: MEM store first, then IF read
        @(negedge clk);
        resp_lat = 1; resp_rdata = 32'h2020_2020; resp_en = 1'b1;
        bif.if_req_i = 1'b1; bif.if_addr_i = 32'h20;
        bif.mem_req_i = 1'b1; bif.mem_we_i = 1'b1; bif.mem_addr_i = 32'h40; bif.mem_wdata_i = 32'h1234_5678;
        wait_bus_req(n);
        chk("tie_first_we",    64'(bif.bus_we_o),    64'd1);
        chk("tie_first_addr",  64'(bif.bus_addr_o),  64'h40);
        chk("tie_first_wdata", 64'(bif.bus_wdata_o), 64'h1234_5678);
        wait_ack(n);
        chk("tie_mem_ack", 64'({bif.mem_ack_o, bif.if_ack_o}), 64'b10);
        chk("tie_mem_rdata", 64'(bif.mem_rdata_o), 64'd0);
        bif.mem_req_i = 1'b0;
        wait_bus_req(n);
        chk("tie_second_addr", 64'(bif.bus_addr_o), 64'h20);
        chk("tie_second_we",   64'(bif.bus_we_o),   64'd0);
        wait_ack(n);
        chk("tie_if_ack", 64'({bif.mem_ack_o, bif.if_ack_o}), 64'b01);
        chk("tie_if_rdata", 64'(bif.if_rdata_o), 64'h2020_2020);
        bif.if_req_i = 1'b0;
        repeat (2) @(negedge clk);

        // MEM burst limit with IF held
        base = grant_log.size();
        resp_lat = 1; resp_rdata = 32'h0000_0077; resp_en = 1'b1;
        bif.if_req_i = 1'b1; bif.if_addr_i = 32'h20;
        bif.mem_req_i = 1'b1; bif.mem_we_i = 1'b0; bif.mem_addr_i = 32'h100;
        mdone = 0; idone = 1'b0; cyc = 0;
        while ((mdone < 6 || !idone) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bif.mem_ack_o) begin
                mdone++;
                if (mdone == 6) bif.mem_req_i = 1'b0;
                else bif.mem_addr_i = 32'h100 + 32'(mdone);
            end
            if (bif.if_ack_o) begin
                idone = 1'b1;
                bif.if_req_i = 1'b0;
            end
        end
        chk("burst_finished", 64'(cyc < 300), 64'd1);
        chk("burst_grants", 64'(grant_log.size() - base), 64'd7);
        for (int i = 0; i < 7; i++) begin
            got = (base + i < grant_log.size()) ? 64'(grant_log[base + i]) : 64'hFFFF_FFFF_FFFF_FFFF;
            chk($sformatf("burst_grant%0d", i), got, 64'(exp_g[i]));
        end
        repeat (2) @(negedge clk);

        // held request through ack cycle -> single transaction
        base = grant_log.size(); ibase = if_acks;
        resp_lat = 2; resp_rdata = 32'h6666_6666; resp_en = 1'b1;
        bif.if_req_i = 1'b1; bif.if_addr_i = 32'h60;
        wait_ack(n);
        @(negedge clk);
        bif.if_req_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("hold_one_grant", 64'(grant_log.size() - base), 64'd1);
        chk("hold_one_ack",   64'(if_acks - ibase), 64'd1);
        chk("hold_idle",      64'(bif.busy_o), 64'd0);

        // timeout: bus never acks
        @(negedge clk);
        resp_en = 1'b0;
        bif.if_req_i = 1'b1; bif.if_addr_i = 32'h70;
        hi = 0; n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bif.bus_req_o) hi++;
            if (bif.if_ack_o) break;
        end
        chk("to_req_cycles", 64'(hi), 64'(TIMEOUT));
        chk("to_if_ack",     64'(bif.if_ack_o), 64'd1);
        chk("to_if_rdata",   64'(bif.if_rdata_o), 64'd0);
        chk("to_err",        64'(bif.err_o), 64'd1);
        bif.if_req_i = 1'b0;
        run_vec(vecs[1], 1'b1, "after_to");

        // asynchronous reset in the middle of a bus access
        resp_en = 1'b0;
        bif.if_req_i = 1'b1; bif.if_addr_i = 32'h80;
        wait_bus_req(n);
        repeat (2) @(negedge clk);
        base = grant_log.size(); ibase = if_acks; mbase = mem_acks;
        rst_n = 1'b0;
        bif.if_req_i = 1'b0;
        #1;
        chk("arst_bus_req", 64'(bif.bus_req_o), 64'd0);
        chk("arst_busy",    64'(bif.busy_o),    64'd0);
        chk("arst_err",     64'(bif.err_o),     64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_ack",   64'((if_acks - ibase) + (mem_acks - mbase)), 64'd0);
        chk("arst_no_grant", 64'(grant_log.size() - base), 64'd0);
        run_vec(vecs[3], 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
